// File: rtl/serial_seq_pkg.sv
// serial_seq_pkg: shared state encoding and sizing helper for the serial shift blocks
package serial_seq_pkg;
  typedef enum logic {IDLE, SHIFT} seq_state_e;
  function automatic int idx_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/piso_register.sv
// piso_register: parallel-in serial-out register with load, shift-enable and zero-fill
module piso_register #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             so_o
);
  logic [WIDTH-1:0] sr_q, sr_d;
  always_comb begin
    sr_d = load_i ? data_i : shift_i ? (LSB_FIRST ? sr_q >> 1 : sr_q << 1) : sr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end
  assign so_o = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
endmodule

// File: rtl/serial_shift_sequencer.sv
// serial_shift_sequencer: handshake-fed controller that streams words out of a PISO register
module serial_shift_sequencer
  import serial_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1,
  localparam int IW       = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic [IW-1:0]    bit_idx
);
  seq_state_e    state_q, state_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;
  logic          last, accept, shift_en;
  always_comb begin
    last       = bit_idx_q == IW'(WIDTH - 1);
    shift_en   = state_q == SHIFT && !hold;
    load_ready = state_q == IDLE || (last && !hold);
    accept     = load_valid && load_ready;
    state_d    = accept ? SHIFT : (shift_en && last) ? IDLE : state_q;
    bit_idx_d  = accept ? '0 : shift_en ? (last ? '0 : bit_idx_q + IW'(1)) : bit_idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
    end
  end
  // a reload on the last-bit edge takes priority over the shift inside the register
  piso_register #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_piso (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .shift_i(shift_en),
    .data_i (data_in),
    .so_o   (so)
  );
  assign so_valid    = shift_en;
  assign frame_start = shift_en && bit_idx_q == '0;
  assign frame_done  = shift_en && last;
  assign busy        = state_q == SHIFT;
  assign bit_idx     = bit_idx_q;
endmodule

// File: tb/tb_serial_shift_sequencer.sv
// tb_serial_shift_sequencer: directed and random frames checked against a word-level model
module tb_serial_shift_sequencer;
  logic       clk = 0, rst = 1, load_valid = 0, hold = 0;
  logic [7:0] data_in = '0;
  logic       load_ready, so, so_valid, frame_start, frame_done, busy;
  logic [2:0] bit_idx;
  logic       load_ready_m, so_m, so_valid_m, frame_start_m, frame_done_m, busy_m;
  logic [2:0] bit_idx_m;
  int n_cmp = 0, n_bad = 0;
  bit         m_active = 0;
  int         m_pos = 0;
  logic [7:0] m_word = '0, cap_l = '0, cap_m = '0;
  logic [7:0] sb[$];
  always #5 clk = ~clk;
  serial_shift_sequencer #(.WIDTH(8), .LSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid), .load_ready(load_ready),
    .hold(hold), .so(so), .so_valid(so_valid), .frame_start(frame_start),
    .frame_done(frame_done), .busy(busy), .bit_idx(bit_idx)
  );
  serial_shift_sequencer #(.WIDTH(8), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid), .load_ready(load_ready_m),
    .hold(hold), .so(so_m), .so_valid(so_valid_m), .frame_start(frame_start_m),
    .frame_done(frame_done_m), .busy(busy_m), .bit_idx(bit_idx_m)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic step(input logic lv, input logic [7:0] d, input logic h, input logic r);
    logic e_valid, e_ready, e_so, e_so_m;
    load_valid = lv; data_in = d; hold = h; rst = r;
    @(negedge clk);
    e_valid = m_active && !h;
    e_ready = !m_active || (m_pos == 7 && !h);
    e_so    = m_active ? m_word[m_pos] : 1'b0;
    e_so_m  = m_active ? m_word[7 - m_pos] : 1'b0;
    chk("so", so, e_so);
    chk("so_msb", so_m, e_so_m);
    chk("so_valid", so_valid, e_valid);
    chk("so_valid_msb", so_valid_m, e_valid);
    chk("load_ready", load_ready, e_ready);
    chk("busy", busy, m_active);
    chk("frame_start", frame_start, e_valid && m_pos == 0);
    chk("frame_done", frame_done, e_valid && m_pos == 7);
    if (m_active || m_pos == 0) chk("bit_idx", bit_idx, m_pos[2:0]);
    if (so_valid) cap_l = {so, cap_l[7:1]};
    if (so_valid_m) cap_m = {cap_m[6:0], so_m};
    if (frame_done) begin
      chk("frame_pending", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        chk("frame_word_lsb", cap_l, sb[0]);
        chk("frame_word_msb", cap_m, sb[0]);
        void'(sb.pop_front());
      end
    end
    if (r) begin
      m_active = 0; m_pos = 0; sb.delete();
    end else if (lv && e_ready) begin
      m_active = 1; m_word = d; m_pos = 0; sb.push_back(d);
    end else if (m_active && !h) begin
      if (m_pos == 7) m_active = 0;
      else m_pos++;
    end
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (2) step(0, 8'h00, 0, 0);
    step(1, 8'hAD, 0, 0);
    repeat (9) step(0, 8'h00, 0, 0);
    repeat (8) step(1, 8'hFF, 0, 0);
    step(1, 8'h00, 0, 0);
    repeat (9) step(0, 8'h00, 0, 0);
    step(1, 8'hAD, 0, 0);
    repeat (3) step(0, 8'h00, 0, 0);
    repeat (3) step(0, 8'h00, 1, 0);
    repeat (6) step(0, 8'h00, 0, 0);
    step(1, 8'hAD, 0, 0);
    repeat (2) step(0, 8'h00, 0, 0);
    step(1, 8'h33, 0, 0);
    repeat (7) step(0, 8'h00, 0, 0);
    step(1, 8'hAD, 0, 0);
    repeat (5) step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);
    repeat (2) step(0, 8'h00, 0, 0);
    step(1, 8'h5A, 0, 0);
    repeat (9) step(0, 8'h00, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_shift_sequencer.md
# serial_shift_sequencer

Controller that sequences a serial shift datapath. It accepts a parallel word over a valid/ready handshake, loads it into a parallel-in/serial-out shift register, and shifts it out one bit per enabled cycle. It supports a stall input and gapless back-to-back frames. It sits between a word-oriented producer and the serial registers driven by `si`/`so` in the sequential_circuits area.

## Interface
- `WIDTH`, default 8: bits per frame; must be ≥ 2.
- `LSB_FIRST`, default 1: 1 shifts bit 0 first; 0 shifts bit WIDTH-1 first.

- `clk` input, 1 bit: the only clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset, sampled on the `clk` rising edge.
- `data_in` input, WIDTH bits: parallel word; sampled only on an accept.
- `load_valid` input, 1 bit: producer offers `data_in`.
- `load_ready` output, 1 bit: sequencer can accept a word this cycle.
- `hold` input, 1 bit: stalls shifting for the current cycle.
- `so` output, 1 bit: serial data out.
- `so_valid` output, 1 bit: `so` carries a frame bit this cycle.
- `frame_start` output, 1 bit: high during the cycle the first bit of a frame is valid.
- `frame_done` output, 1 bit: high during the cycle the last bit of a frame is valid.
- `busy` output, 1 bit: FSM is in SHIFT.
- `bit_idx` output, clog2(WIDTH) bits: index of the frame bit currently on `so` (0 = first).

## Operation
- FSM states:
  - IDLE: reset state.
  - SHIFT: a frame is in progress.
- Accept = `load_valid && load_ready` at a rising edge. On accept:
  - shift register ← `data_in`
  - `bit_idx` ← 0
  - state ← SHIFT
- `load_ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT only when `bit_idx == WIDTH-1 && !hold` (last bit leaving this cycle).
  - 0 otherwise.
- SHIFT, `hold=0`: the bit on `so` is consumed this cycle. At the edge:
  - shift register shifts toward the output end, zero-filling.
  - `bit_idx` increments.
- SHIFT, `hold=1`: shift register and `bit_idx` freeze; `so` keeps its value; `so_valid=0`.
- Last bit (`bit_idx == WIDTH-1`, `hold=0`):
  - with accept: reload the new word, `bit_idx` ← 0, stay in SHIFT.
  - without accept: state ← IDLE.
- Output decode:
  - `so` = shift register bit 0 if LSB_FIRST, else bit WIDTH-1.
  - `so_valid` = SHIFT && !hold.
  - `frame_start` = `so_valid && bit_idx == 0`.
  - `frame_done` = `so_valid && bit_idx == WIDTH-1`.
- `load_valid` while not ready: ignored; the word is not captured and the producer must keep it presented.
- Accept is sampled in the same edge as the last-bit shift; there is no ambiguity between the two events.
- Reset mid-frame: the frame is abandoned silently. No `frame_done` is issued and the partial frame is not resumed.
- Reset values:
  - state IDLE, shift register 0, `bit_idx` 0.
  - `so`=0, `so_valid`=0, `frame_start`=0, `frame_done`=0, `busy`=0, `load_ready`=1 (combinational, after reset).

## Timing
- Accept at edge E: first bit valid in the cycle after E; with no holds, last bit valid WIDTH cycles after E.
- Each `hold` cycle adds exactly one cycle of latency and never drops or duplicates a bit.
- Back-to-back frames are gapless: `so_valid` stays 1 across the frame boundary when the next word is accepted in the last-bit cycle.
- Throughput is one bit per non-held cycle; one frame per WIDTH cycles at most.
- Outputs are combinational from registered state and `hold`. No combinational path exists from `load_valid` or `data_in` to any output.

## Structure
- Shared package `serial_seq_pkg` contains:
  - state enum {IDLE, SHIFT}
  - function returning clog2(WIDTH)
- Sub-module `piso_register` (WIDTH, LSB_FIRST): load, shift-enable, serial out, zero-fill. It is the datapath the FSM drives and is reusable by other serial blocks.
- The top level holds the FSM, `bit_idx` counter and handshake/strobe decode.

## Test plan
- Single frame, WIDTH=8, LSB_FIRST=1, `data_in`=0xAD, no hold:
  - `so` = 1,0,1,1,0,1,0,1 on 8 consecutive cycles.
  - `frame_start` on the 1st of these cycles, `frame_done` on the 8th.
  - Returns to IDLE with `busy`=0.
- MSB-first, `data_in`=0xAD: `so` = 1,0,1,0,1,1,0,1.
- Back-to-back 0xFF then 0x00 with `load_valid` held high:
  - 16 contiguous `so_valid` cycles, second accept in the cycle `frame_done`=1.
  - `so` = eight 1s then eight 0s.
- `hold`=1 for 3 cycles at `bit_idx`=3 of 0xAD:
  - `so_valid`=0 for those cycles, `so` steady at bit 3 (1).
  - Full sequence intact; `frame_done` 3 cycles later than in the no-hold case.
- `load_valid` at `bit_idx`=2 of a frame: `load_ready`=0, the word is not captured, and the frame continues unchanged.
- `rst` asserted at `bit_idx`=5: after the reset edge, IDLE, `so`=0, `so_valid`=0, and no `frame_done` is emitted. A new 0x5A accepted afterwards shifts correctly.
